// File: rtl/fnd_sum_display.sv
// fnd_sum_display: captures a binary sum and converts it to BCD by shift-add-3 (one bit per clock).
// It also scans a 4-digit common-anode seven-segment display. Leading zeros are blanked.
// Ports: i_clk/i_reset (async active-low), i_valid/i_sum capture, o_busy, o_fnd_com (digit, low), o_fnd_font (segs, low).
module fnd_sum_display #(
  parameter int SUM_W       = 9,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [SUM_W-1:0] i_sum,
  output logic             o_busy,
  output logic [3:0]       o_fnd_com,
  output logic [7:0]       o_fnd_font
);

  localparam int CW = $clog2(SUM_W + 1);
  localparam int RW = $clog2(REFRESH_DIV);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t           state, state_nxt;
  logic [SUM_W-1:0] shift_q;
  logic [15:0]      bcd_q;
  logic [CW-1:0]    bit_cnt;
  logic [15:0]      disp_q;

  logic [15:0]      bcd_adj;
  logic [15:0]      bcd_shifted;
  logic [SUM_W-1:0] shift_shifted;
  logic             last_bit;

  logic [RW-1:0]    refresh_cnt;
  logic [1:0]       digit_idx;
  logic [3:0]       nibble;
  logic             blank;
  logic [7:0]       font_nxt;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // One double-dabble step: correct each nibble, then shift {bcd, shift} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shifted   = {bcd_adj[14:0], shift_q[SUM_W-1]};
    shift_shifted = shift_q << 1;
    last_bit      = (bit_cnt == CW'(SUM_W - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid)  state_nxt = CONVERT;
      CONVERT: if (last_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shift_q <= '0;
      bcd_q   <= '0;
      bit_cnt <= '0;
      disp_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            shift_q <= i_sum;
            bcd_q   <= '0;
            bit_cnt <= '0;
          end
        end
        CONVERT: begin
          shift_q <= shift_shifted;
          bcd_q   <= bcd_shifted;
          bit_cnt <= bit_cnt + CW'(1);
          // The display takes the result of the final shift directly,
          // so it never sees an intermediate accumulator value.
          if (last_bit) disp_q <= bcd_shifted;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state == CONVERT);

  // Digit scan runs free of the converter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // A digit is blank when it and every higher nibble are zero; the ones digit always shows.
  always_comb begin
    nibble = disp_q[{digit_idx, 2'b00} +: 4];
    case (digit_idx)
      2'd1:    blank = (disp_q[15:4]  == 12'd0);
      2'd2:    blank = (disp_q[15:8]  == 8'd0);
      2'd3:    blank = (disp_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    font_nxt = blank ? 8'hFF : seg7(nibble);
  end

  // Select and segments are registered together so they always refer to the same digit.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_fnd_com  <= 4'b1110;
      o_fnd_font <= 8'hC0;
    end else begin
      o_fnd_com  <= ~(4'b0001 << digit_idx);
      o_fnd_font <= font_nxt;
    end
  end

endmodule
